alu_seq_control: RTL and testbench
==================================

# alu_seq_control

Parametrised sequencing front-end for the shared combinational ALU. It sits between the stage controller, register file and ALU. During `STAGE_PC_UPDATE` it steers the PC increment into the ALU. Otherwise it issues single-cycle ops with a registered result, and runs `ALU_OP_MUL` as an iterative shift-add sequence over several cycles on the same ALU adder, holding `busy` so the stage controller stalls.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of PC, operands and result.
- `PC_INC`, 1, constant added to PC in `STAGE_PC_UPDATE`.
- `MUL_EN`, 1, 1 = iterative multiply; 0 = `ALU_OP_MUL` forwarded to the ALU as a single-cycle op.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stage`  in  3  current CPU stage.
- `start`  in  1  issue request for `alu_operation` this cycle.
- `alu_operation`  in  5  requested op code.
- `PC_output`  in  WIDTH  current PC.
- `reg_value_0`, `reg_value_1`  in  WIDTH  operands (multiplicand, multiplier for MUL).
- `alu_result`  in  WIDTH  combinational result from ALU.
- `alu_in0`, `alu_in1`  out  WIDTH  ALU operands (combinational).
- `alu_op_select`  out  5  ALU op (combinational).
- `result`  out  WIDTH  registered op result.
- `result_valid`  out  1  one-cycle pulse, `result` updated this cycle.
- `busy`  out  1  multiply in progress; `start` ignored.

## Operation
- States: IDLE, MUL. Reset → IDLE, `result`=0, `result_valid`=0, `busy`=0.
- ALU mux priority:
  - In MUL: `alu_in0`=acc, `alu_in1`=mcand, `alu_op_select`=`ALU_OP_ADD`.
  - Else if `stage`==`STAGE_PC_UPDATE`: `PC_output`, `PC_INC`, `ALU_OP_ADD`.
  - Else: `reg_value_0`, `reg_value_1`, `alu_operation`.
- Accepted issue: `start`=1, state IDLE, `stage`!=`STAGE_PC_UPDATE`. Otherwise `start` is ignored with no side effect.
- Non-MUL issue, or any issue with `MUL_EN`=0: next edge `result`<=`alu_result`, `result_valid`<=1.
- MUL issue with `MUL_EN`=1: next edge acc<=0, mcand<=`reg_value_0`, mplier<=`reg_value_1`, state<=MUL.
- Each MUL cycle:
  - If mplier[0]: acc<=`alu_result`.
  - mcand<=mcand<<1 (bits shifted out discarded); mplier<=mplier>>1.
  - When post-shift mplier==0: state<=IDLE, `result`<=acc-next, `result_valid`<=1.
- Arithmetic: product is low WIDTH bits, unsigned (identical low bits for two's complement).
- MUL cycle count N = max(1, index of MSB set in multiplier + 1); multiplier 0 gives N=1, result 0.
- `result` holds its value between pulses.
- `rst` in MUL aborts: IDLE, partial product discarded, no `result_valid`.

## Timing
- Non-MUL: `start` in cycle 0 → `result_valid` in cycle 1.
- MUL: `start` in cycle 0 → `busy`=1 in cycles 1..N → `result_valid`=1 and `busy`=0 in cycle N+1.
- A new `start` is accepted in cycle N+1 (back-to-back).
- ALU outputs are purely combinational from state, `stage` and inputs, with no added latency.
- `busy` is a registered state decode; `result_valid` is registered.

## Structure
- Shared package `arch_defines.v`:
  - Existing `STAGE_PC_UPDATE`, `ALU_OP_ADD`.
  - New `ALU_OP_MUL`.
  - New state encodings `ALU_SEQ_IDLE`, `ALU_SEQ_MUL`.
- One sub-module, `mul_shift_regs`: holds mcand/mplier shift registers and the done flag, parameterised by `WIDTH`.
- Top level holds the FSM, acc, result registers and the ALU mux.

## Test plan
- Reset, then `stage`=`STAGE_PC_UPDATE`, `PC_output`=0x10 → `alu_in0`=0x10, `alu_in1`=1, `alu_op_select`=`ALU_OP_ADD`. `start`=1 in this stage → no `result_valid`.
- ADD issue 5+9 → `result`=14 with `result_valid` in cycle 1, `busy` never high.
- MUL 6×7 → `busy` cycles 1–3, `result`=42 with `result_valid` in cycle 4. MUL 0x1234×0 → `result`=0 in cycle 2.
- MUL 0xFFFFFFFF×0xFFFFFFFF (`WIDTH`=32) → N=32, `result`=1. `start` pulses mid-run → ignored, no extra `result_valid`.
- `rst` in cycle 2 of MUL 3×5 → `busy`=0, `result`=0, no `result_valid`. Next ADD 1+1 → `result`=2 in 1 cycle.
- `MUL_EN`=0, `WIDTH`=16, MUL issue → `alu_op_select`=`ALU_OP_MUL`, `result`=`alu_result` in cycle 1, `busy` never high.

Source files
------------

// File: rtl/alu_seq_control_pkg.sv
// Shared architecture defines for the ALU sequencing front-end: stage and op
// codes plus the sequencer state encoding.
package alu_seq_control_pkg;

    localparam logic [2:0] STAGE_PC_UPDATE = 3'd4;

    localparam logic [4:0] ALU_OP_ADD = 5'd0;
    localparam logic [4:0] ALU_OP_MUL = 5'd10;

    typedef enum logic [0:0] {
        ALU_SEQ_IDLE = 1'b0,
        ALU_SEQ_MUL  = 1'b1
    } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_control_mul_regs.sv
// Multiplicand/multiplier shift registers for the iterative shift-add multiply.
// done_o flags that the multiplier becomes zero after this cycle's shift.
module mul_shift_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] mcand_o,
    output logic             mplier_lsb_o,
    output logic             done_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
        end else if (shift_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign mcand_o      = mcand_q;
    assign mplier_lsb_o = mplier_q[0];
    assign done_o       = (mplier_q >> 1) == '0;

endmodule

// File: rtl/alu_seq_control.sv
// Sequencing front-end for the shared ALU: PC increment steering, single-cycle
// ops with a registered result, and an iterative shift-add multiply.
module alu_seq_control
    import alu_seq_control_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 1,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       stage,
    input  logic             start,
    input  logic [4:0]       alu_operation,
    input  logic [WIDTH-1:0] PC_output,
    input  logic [WIDTH-1:0] reg_value_0,
    input  logic [WIDTH-1:0] reg_value_1,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [4:0]       alu_op_select,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output alu_seq_state_e   dbg_state
);

    // Handshake: an issue is accepted when start=1 while IDLE and not in the
    // PC update stage; busy=1 means start is ignored. result_valid is a
    // one-cycle pulse with result updated in the same cycle.

    alu_seq_state_e   state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;

    logic             issue_ok, mul_issue;
    logic             mul_load, mul_shift;
    logic [WIDTH-1:0] mcand;
    logic             mplier_lsb, mul_done;

    mul_shift_regs #(.WIDTH(WIDTH)) u_mul_regs (
        .clk          (clk),
        .rst          (rst),
        .load_i       (mul_load),
        .shift_i      (mul_shift),
        .mcand_i      (reg_value_0),
        .mplier_i     (reg_value_1),
        .mcand_o      (mcand),
        .mplier_lsb_o (mplier_lsb),
        .done_o       (mul_done)
    );

    assign issue_ok  = start && (state_q == ALU_SEQ_IDLE) && (stage != STAGE_PC_UPDATE);
    assign mul_issue = issue_ok && MUL_EN && (alu_operation == ALU_OP_MUL);

    // The multiply borrows the ALU adder, so it overrides every other source.
    always_comb begin
        alu_in0       = reg_value_0;
        alu_in1       = reg_value_1;
        alu_op_select = alu_operation;
        if (state_q == ALU_SEQ_MUL) begin
            alu_in0       = acc_q;
            alu_in1       = mcand;
            alu_op_select = ALU_OP_ADD;
        end else if (stage == STAGE_PC_UPDATE) begin
            alu_in0       = PC_output;
            alu_in1       = WIDTH'(PC_INC);
            alu_op_select = ALU_OP_ADD;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        mul_load       = 1'b0;
        mul_shift      = 1'b0;
        case (state_q)
            ALU_SEQ_IDLE: begin
                if (mul_issue) begin
                    mul_load = 1'b1;
                    acc_d    = '0;
                    state_d  = ALU_SEQ_MUL;
                end else if (issue_ok) begin
                    result_d       = alu_result;
                    result_valid_d = 1'b1;
                end
            end
            ALU_SEQ_MUL: begin
                mul_shift = 1'b1;
                if (mplier_lsb) acc_d = alu_result;
                if (mul_done) begin
                    state_d        = ALU_SEQ_IDLE;
                    result_d       = acc_d;
                    result_valid_d = 1'b1;
                end
            end
            default: state_d = ALU_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ALU_SEQ_IDLE;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == ALU_SEQ_MUL);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_seq_control.sv
// Bench for alu_seq_control: a 32-bit multiplying instance and a 16-bit
// instance with the multiplier disabled, both driving a behavioural ALU.
module tb_alu_seq_control;
    import alu_seq_control_pkg::*;

    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- 32-bit instance, multiply enabled ----------------
    logic [2:0]     stage = 3'd0;
    logic           start = 1'b0;
    logic [4:0]     alu_operation = 5'd0;
    logic [31:0]    pc_output = 32'd0;
    logic [31:0]    reg_value_0 = 32'd0, reg_value_1 = 32'd0;
    logic [31:0]    alu_result, alu_in0, alu_in1, result;
    logic [4:0]     alu_op_select;
    logic           result_valid, busy;
    alu_seq_state_e dbg_state;

    // ---------------- 16-bit instance, multiply forwarded ----------------
    logic           b_start = 1'b0;
    logic [4:0]     b_operation = 5'd0;
    logic [15:0]    b_reg0 = 16'd0, b_reg1 = 16'd0;
    logic [15:0]    b_alu_result, b_in0, b_in1, b_result;
    logic [4:0]     b_op_select;
    logic           b_valid, b_busy;
    alu_seq_state_e b_dbg_state;

    function automatic logic [31:0] alu_arith(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_OP_ADD: return a + b;
            OP_SUB:     return a - b;
            OP_AND:     return a & b;
            OP_OR:      return a | b;
            OP_XOR:     return a ^ b;
            ALU_OP_MUL: return a * b;
            default:    return a;
        endcase
    endfunction

    assign alu_result   = alu_arith(alu_op_select, alu_in0, alu_in1);
    assign b_alu_result = 16'(alu_arith(b_op_select, {16'h0, b_in0}, {16'h0, b_in1}));

    alu_seq_control #(.WIDTH(32), .PC_INC(1), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .stage(stage), .start(start),
        .alu_operation(alu_operation), .PC_output(pc_output),
        .reg_value_0(reg_value_0), .reg_value_1(reg_value_1),
        .alu_result(alu_result), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_op_select(alu_op_select), .result(result),
        .result_valid(result_valid), .busy(busy), .dbg_state(dbg_state)
    );

    alu_seq_control #(.WIDTH(16), .PC_INC(1), .MUL_EN(1'b0)) dut16 (
        .clk(clk), .rst(rst), .stage(3'd0), .start(b_start),
        .alu_operation(b_operation), .PC_output(16'h0),
        .reg_value_0(b_reg0), .reg_value_1(b_reg1),
        .alu_result(b_alu_result), .alu_in0(b_in0), .alu_in1(b_in1),
        .alu_op_select(b_op_select), .result(b_result),
        .result_valid(b_valid), .busy(b_busy), .dbg_state(b_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [31:0] e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, result, e);
            last_result = e;
        end
    endtask

    // Reference product and cycle count from plain arithmetic.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return p[31:0];
    endfunction

    function automatic int ref_mul_cycles(input logic [31:0] b);
        int n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        stage = 3'd0; start = 1'b1; alu_operation = op; reg_value_0 = a; reg_value_1 = b;
        #1;
        chk("mux_in0", alu_in0, a);
        chk("mux_in1", alu_in1, b);
        chk("mux_op", 32'(alu_op_select), 32'(op));
        exp_q.push_back(alu_arith(op, a, b));
        tick();
        start = 1'b0;
        chk("alu_valid", 32'(result_valid), 32'd1);
        chk("alu_busy", 32'(busy), 32'd0);
        check_result("alu");
    endtask

    task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input bit noisy);
        int cycles = 0;
        stage = 3'd0; start = 1'b1; alu_operation = ALU_OP_MUL; reg_value_0 = a; reg_value_1 = b;
        #1;
        chk("mul_busy_c0", 32'(busy), 32'd0);
        exp_q.push_back(ref_mul(a, b));
        tick();
        start = 1'b0;
        while (busy && cycles < 40) begin
            chk("mul_no_valid", 32'(result_valid), 32'd0);
            chk("mul_alu_op", 32'(alu_op_select), 32'(ALU_OP_ADD));
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                alu_operation = 5'($urandom_range(0, 10));
                reg_value_0 = $urandom;
                reg_value_1 = $urandom;
                stage = 3'($urandom_range(0, 7));
            end
            cycles++;
            tick();
        end
        start = 1'b0; stage = 3'd0;
        chk("mul_cycles", 32'(cycles), 32'(ref_mul_cycles(b)));
        chk("mul_busy_done", 32'(busy), 32'd0);
        chk("mul_valid", 32'(result_valid), 32'd1);
        check_result("mul");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_valid", 32'(result_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_hold", result, last_result);
        end
    endtask

    task automatic issue_b_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        b_start = 1'b1; b_operation = ALU_OP_MUL; b_reg0 = a; b_reg1 = b;
        #1;
        chk("b_mux_op", 32'(b_op_select), 32'(ALU_OP_MUL));
        chk("b_mux_in0", 32'(b_in0), 32'(a));
        tick();
        b_start = 1'b0;
        chk("b_valid", 32'(b_valid), 32'd1);
        chk("b_busy", 32'(b_busy), 32'd0);
        chk("b_result", 32'(b_result), {16'h0, p[15:0]});
        tick();
        chk("b_valid_pulse", 32'(b_valid), 32'd0);
        chk("b_busy_idle", 32'(b_busy), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [4:0] ops[6];
        ops = '{ALU_OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, ALU_OP_MUL};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_result", result, 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ALU_SEQ_IDLE));
        chk("rst_b_result", 32'(b_result), 32'd0);
        rst = 1'b0;

        // PC update stage steers PC+1 and blocks issue.
        stage = STAGE_PC_UPDATE; pc_output = 32'h10; start = 1'b1; alu_operation = OP_SUB;
        reg_value_0 = 32'd3; reg_value_1 = 32'd4;
        #1;
        chk("pc_in0", alu_in0, 32'h10);
        chk("pc_in1", alu_in1, 32'd1);
        chk("pc_op", 32'(alu_op_select), 32'(ALU_OP_ADD));
        tick();
        chk("pc_no_valid", 32'(result_valid), 32'd0);
        chk("pc_no_busy", 32'(busy), 32'd0);
        start = 1'b0; stage = 3'd0;

        issue_alu(ALU_OP_ADD, 32'd5, 32'd9);
        chk("add_5_9", result, 32'd14);
        idle_cycles(2);

        issue_mul(32'd6, 32'd7, 1'b0);
        chk("mul_6_7", result, 32'd42);
        issue_mul(32'h1234, 32'd0, 1'b0);
        chk("mul_by_zero", result, 32'd0);
        idle_cycles(1);
        issue_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("mul_all_ones", result, 32'd1);
        idle_cycles(2);

        // Reset during a multiply discards it.
        stage = 3'd0; start = 1'b1; alu_operation = ALU_OP_MUL; reg_value_0 = 32'd3; reg_value_1 = 32'd5;
        tick();
        start = 1'b0;
        tick();
        chk("abort_busy_c2", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        last_result = 32'd0;
        idle_cycles(1);
        issue_alu(ALU_OP_ADD, 32'd1, 32'd1);
        chk("add_after_abort", result, 32'd2);

        // Back-to-back random mix: each issue starts in the cycle the previous result appears.
        for (int i = 0; i < 30; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 5)];
            a  = $urandom;
            b  = $urandom;
            if (op == ALU_OP_MUL) begin
                b = b & ((32'd1 << $urandom_range(0, 12)) - 32'd1);
                issue_mul(a, b, 1'($urandom_range(0, 1)));
            end else begin
                issue_alu(op, a, b);
            end
        end
        idle_cycles(1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Multiply forwarded as a single-cycle op on the 16-bit instance.
        issue_b_mul(16'd300, 16'd500);
        for (int i = 0; i < 4; i++) issue_b_mul(16'($urandom), 16'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
